video_deser7: RTL and testbench

Soft 1:7 deserializer with word alignment: the receive-side counterpart of the 7:1 video serializer. Samples one serial bit per `clk` on `din`, assembles 7-bit words with the first received bit in `q[0]`, and emits a word strobe plus a 4/7-duty word-rate clock. Supports manual bitslip (`calib`) or automatic alignment to a fixed training pattern. Intended for loopback checking of the serializer on-board and for soft LVDS/video receive paths.

---
 rtl/video_deser7_if.sv | 38 +++
 rtl/video_deser7.sv | 187 ++++++++++++++++++
 tb/tb_video_deser7.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/video_deser7_if.sv
`default_nettype none
// ============================================================================
// Module      : video_deser7_if
// Description : Bundle of the serial-in / word-out signals of the 1:7
//               deserializer. The deserializer connects through the slave
//               modport. The master modport is for whatever drives the
//               serial line and consumes the words.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   din        serial data, one bit per clk
//   calib      manual bitslip request (rising edge)
//   q[6:0]     last assembled word, first received bit in q[0]
//   q_valid    one-cycle strobe when q updates
//   pclk       word-rate clock, 4/7 duty
//   locked     automatic alignment achieved
//   slip_count slips executed since reset, mod 7
// ============================================================================
interface video_deser7_if;
  logic       din;
  logic       calib;
  logic [6:0] q;
  logic       q_valid;
  logic       pclk;
  logic       locked;
  logic [2:0] slip_count;

  modport slave (
    input  din, calib,
    output q, q_valid, pclk, locked, slip_count
  );

  modport master (
    output din, calib,
    input  q, q_valid, pclk, locked, slip_count
  );
endinterface
`default_nettype wire

// File: rtl/video_deser7.sv
`default_nettype none
// ============================================================================
// Module      : video_deser7
// Description : Soft 1:7 deserializer with word alignment. It shifts in one
//               bit per clk and emits a 7-bit word every 7 cycles, with a
//               strobe and a 4/7-duty word clock. A bitslip holds the phase
//               counter for one extra cycle, which moves the word boundary one
//               bit later. A slip is requested either by a rising edge on
//               calib or by the automatic training-pattern aligner.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk   bit clock, posedge
//   rst   synchronous active-high reset
//   bus   video_deser7_if.slave (din, calib in; q, q_valid, pclk, locked,
//         slip_count out)
// ============================================================================
module video_deser7 #(
  parameter logic [6:0] ALIGN_PATTERN = 7'b1010101,
  parameter int         LOCK_COUNT    = 4,
  parameter int         UNLOCK_COUNT  = 2,
  parameter int         AUTO_ALIGN    = 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  video_deser7_if.slave      bus
);

  localparam logic [3:0] c_LOCK_CNT   = 4'(LOCK_COUNT);
  localparam logic [3:0] c_UNLOCK_CNT = 4'(UNLOCK_COUNT);
  localparam logic [2:0] c_PH_LAST    = 3'd6;

  typedef enum logic [0:0] {
    S_SEARCH = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  // datapath registers
  logic [6:0] r_sr;
  logic [2:0] r_ph;
  logic [6:0] r_q;
  logic       r_q_valid;
  logic       r_pclk;
  logic [2:0] r_slip_count;
  logic       r_slip_pending;
  logic       r_calib_d;

  // aligner registers
  state_t     r_state;
  logic [3:0] r_match_cnt;
  logic [3:0] r_miss_cnt;
  logic       r_locked;

  // combinational
  logic [6:0] w_word;
  logic       w_at_end;
  logic       w_emit;
  logic       w_do_slip;
  logic [2:0] w_ph_next;
  logic       w_calib_rise;
  logic       w_req;
  state_t     w_state_next;
  logic [3:0] w_match_next;
  logic [3:0] w_miss_next;
  logic       w_locked_next;
  logic       w_auto_req;
  logic [3:0] w_match_inc;
  logic [3:0] w_miss_inc;

  // The word includes the bit being sampled on this edge.
  assign w_word       = {bus.din, r_sr[6:1]};
  assign w_at_end     = (r_ph == c_PH_LAST);
  assign w_do_slip    = w_at_end &&  r_slip_pending;
  assign w_emit       = w_at_end && !r_slip_pending;
  // A slip parks the phase at 6 for one extra cycle instead of wrapping.
  assign w_ph_next    = w_do_slip ? c_PH_LAST :
                        (w_at_end ? 3'd0 : r_ph + 3'd1);
  assign w_calib_rise = bus.calib && !r_calib_d;
  assign w_req        = (AUTO_ALIGN != 0) ? w_auto_req : w_calib_rise;
  assign w_match_inc  = r_match_cnt + 4'd1;
  assign w_miss_inc   = r_miss_cnt + 4'd1;

  // --------------------------------------------------------------------------
  // Datapath: shift register, phase, word output, slip bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr           <= 7'd0;
      r_ph           <= 3'd0;
      r_q            <= 7'd0;
      r_q_valid      <= 1'b0;
      r_pclk         <= 1'b0;
      r_slip_count   <= 3'd0;
      r_slip_pending <= 1'b0;
      r_calib_d      <= 1'b0;
    end else begin
      r_sr      <= w_word;
      r_ph      <= w_ph_next;
      r_pclk    <= (w_ph_next <= 3'd3);
      r_calib_d <= bus.calib;
      r_q_valid <= w_emit;
      if (w_emit) begin
        r_q <= w_word;
      end
      // The slip edge has priority, so a request arriving on it is dropped.
      if (w_do_slip) begin
        r_slip_pending <= 1'b0;
        r_slip_count   <= (r_slip_count == 3'd6) ? 3'd0 : r_slip_count + 3'd1;
      end else if (w_req) begin
        r_slip_pending <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Aligner FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_SEARCH;
      r_match_cnt <= 4'd0;
      r_miss_cnt  <= 4'd0;
      r_locked    <= 1'b0;
    end else if (AUTO_ALIGN != 0) begin
      r_state     <= w_state_next;
      r_match_cnt <= w_match_next;
      r_miss_cnt  <= w_miss_next;
      r_locked    <= w_locked_next;
    end
  end

  // --------------------------------------------------------------------------
  // Aligner FSM: next state. The FSM only acts on emit edges.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_match_next  = r_match_cnt;
    w_miss_next   = r_miss_cnt;
    w_locked_next = r_locked;
    w_auto_req    = 1'b0;
    if (w_emit) begin
      case (r_state)
        S_SEARCH: begin
          if (w_word == ALIGN_PATTERN) begin
            if (w_match_inc == c_LOCK_CNT) begin
              w_state_next  = S_LOCKED;
              w_locked_next = 1'b1;
              w_match_next  = 4'd0;
              w_miss_next   = 4'd0;
            end else begin
              w_match_next = w_match_inc;
            end
          end else begin
            w_match_next = 4'd0;
            w_auto_req   = 1'b1;
          end
        end
        S_LOCKED: begin
          if (w_word != ALIGN_PATTERN) begin
            if (w_miss_inc == c_UNLOCK_CNT) begin
              // Drop lock without slipping; the next word is re-evaluated.
              w_state_next  = S_SEARCH;
              w_locked_next = 1'b0;
              w_match_next  = 4'd0;
              w_miss_next   = 4'd0;
            end else begin
              w_miss_next = w_miss_inc;
            end
          end else begin
            w_miss_next = 4'd0;
          end
        end
        default: begin
          w_state_next = S_SEARCH;
        end
      endcase
    end
  end

  assign bus.q          = r_q;
  assign bus.q_valid    = r_q_valid;
  assign bus.pclk       = r_pclk;
  assign bus.locked     = r_locked;
  assign bus.slip_count = r_slip_count;

endmodule
`default_nettype wire

// File: tb/tb_video_deser7.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_deser7
// Description : Directed bench for video_deser7. One instance runs with manual
//               bitslip and one with automatic alignment. Both share clk, rst
//               and calib, and each is fed a repeating 7'h55 training stream.
//               The automatic stream starts at pattern bit 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_deser7;

  logic clk;
  logic rst;

  video_deser7_if bus_m ();
  video_deser7_if bus_a ();

  video_deser7 #(
    .ALIGN_PATTERN (7'b1010101),
    .LOCK_COUNT    (4),
    .UNLOCK_COUNT  (2),
    .AUTO_ALIGN    (0)
  ) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  video_deser7 #(
    .ALIGN_PATTERN (7'b1010101),
    .LOCK_COUNT    (4),
    .UNLOCK_COUNT  (2),
    .AUTO_ALIGN    (1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         k     = 0;
  int         flip1 = -1;
  int         flip2 = -1;
  int         flip3 = -1;
  logic [6:0] pat   = 7'h55;
  logic       prev_lock = 1'b0;
  int         pclk_hi;
  int         vm_idx[$];
  logic [6:0] vm_q[$];
  int         va_idx[$];
  int         la_rise[$];
  int         la_fall[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Drives stream bit k to both DUTs, clocks one edge, then logs events.
  task automatic adv();
    bus_m.din = pat[k % 7];
    bus_a.din = pat[(k + 3) % 7] ^ ((k == flip1) || (k == flip2) || (k == flip3));
    @(posedge clk);
    #1;
    if (bus_m.q_valid) begin
      vm_idx.push_back(k);
      vm_q.push_back(bus_m.q);
    end
    if (bus_a.q_valid) va_idx.push_back(k);
    if (bus_a.locked && !prev_lock) la_rise.push_back(k);
    if (!bus_a.locked && prev_lock) la_fall.push_back(k);
    prev_lock = bus_a.locked;
    k++;
  endtask

  initial begin
    bus_m.calib = 1'b0;
    bus_a.calib = 1'b0;
    bus_m.din   = 1'b0;
    bus_a.din   = 1'b0;
    rst         = 1'b1;

    // ---------------- reset with random inputs ----------------
    for (int i = 0; i < 4; i++) begin
      bus_m.din   = 1'($urandom);
      bus_a.din   = 1'($urandom);
      bus_m.calib = 1'($urandom);
      bus_a.calib = bus_m.calib;
      @(posedge clk);
      #1;
    end
    chk("rst_q_m",       32'(bus_m.q),          0);
    chk("rst_qv_m",      32'(bus_m.q_valid),    0);
    chk("rst_pclk_m",    32'(bus_m.pclk),       0);
    chk("rst_slip_m",    32'(bus_m.slip_count), 0);
    chk("rst_q_a",       32'(bus_a.q),          0);
    chk("rst_lock_a",    32'(bus_a.locked),     0);
    chk("rst_pclk_a",    32'(bus_a.pclk),       0);

    rst         = 1'b0;
    bus_m.calib = 1'b0;
    bus_a.calib = 1'b0;
    k           = 0;

    // ---------------- first word: strobe on the 7th edge ----------------
    for (int i = 0; i < 7; i++) begin
      adv();
      chk($sformatf("first_qv_%0d", i), 32'(bus_m.q_valid), (i == 6) ? 1 : 0);
      chk($sformatf("first_pclk_%0d", i), 32'(bus_m.pclk), ((i <= 2) || (i == 6)) ? 1 : 0);
    end
    chk("first_q_m", 32'(bus_m.q), 32'h55);

    // ---------------- pclk duty over two words ----------------
    pclk_hi = 0;
    for (int i = 0; i < 14; i++) begin
      adv();
      if (bus_m.pclk) pclk_hi++;
    end
    chk("pclk_hi_14", pclk_hi, 8);

    // ---------------- calib pulse, then a second one while pending ----------------
    while (k < 22) adv();
    bus_m.calib = 1'b1; bus_a.calib = 1'b1; adv();   // k=22: request
    bus_m.calib = 1'b0; bus_a.calib = 1'b0; adv();   // k=23
    bus_m.calib = 1'b1; bus_a.calib = 1'b1; adv();   // k=24: dropped
    bus_m.calib = 1'b0; bus_a.calib = 1'b0;
    while (k < 28) adv();                             // k=27 is the slip edge
    chk("slip_qv",   32'(bus_m.q_valid), 0);
    chk("slip_pclk", 32'(bus_m.pclk),    0);
    chk("slip_cnt1", 32'(bus_m.slip_count), 1);
    adv();                                            // k=28 emits shifted word
    chk("post_slip_qv", 32'(bus_m.q_valid), 1);
    chk("post_slip_q",  32'(bus_m.q),       32'h6A);

    // ---------------- auto: corrupt one word, then two in a row ----------------
    flip1 = 62;
    flip2 = 83;
    flip3 = 90;
    while (k < 130) adv();

    chk("m_nvalid", vm_idx.size(), 18);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("m_vidx_%0d", i), vm_idx[i], (i < 3) ? 6 + 7 * i : 28 + 7 * (i - 3));
      chk($sformatf("m_vq_%0d", i), 32'(vm_q[i]), (i < 3) ? 32'h55 : 32'h6A);
    end
    chk("m_slip_final", 32'(bus_m.slip_count), 1);
    chk("m_locked",     32'(bus_m.locked),     0);

    for (int i = 0; i < 6; i++) begin
      chk($sformatf("a_vidx_%0d", i), va_idx[i], (i < 5) ? 6 + 8 * i : 45);
    end
    chk("a_nrise",  la_rise.size(), 2);
    chk("a_rise0",  la_rise[0], 59);
    chk("a_rise1",  la_rise[1], 122);
    chk("a_nfall",  la_fall.size(), 1);
    chk("a_fall0",  la_fall[0], 94);
    chk("a_slip",   32'(bus_a.slip_count), 4);
    chk("a_q",      32'(bus_a.q), 32'h55);
    chk("a_locked", 32'(bus_a.locked), 1);

    // ---------------- one-edge reset while locked ----------------
    rst = 1'b1;
    adv();
    rst = 1'b0;
    chk("rst2_lock", 32'(bus_a.locked),     0);
    chk("rst2_q",    32'(bus_a.q),          0);
    chk("rst2_slip", 32'(bus_a.slip_count), 0);
    chk("rst2_qv",   32'(bus_a.q_valid),    0);

    k         = 0;
    flip1     = -1;
    flip2     = -1;
    flip3     = -1;
    prev_lock = 1'b0;
    la_rise.delete();
    la_fall.delete();
    while (k < 70) adv();
    chk("relock_nrise", la_rise.size(), 1);
    if (la_rise.size() > 0) chk("relock_rise0", la_rise[0], 59);
    chk("relock_slip", 32'(bus_a.slip_count), 4);
    chk("relock_q",    32'(bus_a.q), 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
